// File: rtl/operand_register_a_pp.sv
`default_nettype none
// ============================================================================
// Module   : operand_register_a_pp
// Purpose  : Ping-pong MAX_DIM x MAX_DIM A-operand banks with a skewed,
//            registered systolic feed and an internal stream FSM.
//            Define OPERAND_TRANSPOSE_EN to add transpose_i (A^T feed).
// Revision : 1.0 - initial release
// ============================================================================
module operand_register_a_pp #(
    parameter  int BUS_WIDTH  = 32,
    parameter  int DATA_WIDTH = 8,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int AW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
    localparam int CW         = $clog2(3*MAX_DIM-2)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BUS_WIDTH-1:0] pwdata_i,
    input  logic [MAX_DIM-1:0]   pstrb_i,
    input  logic [AW-1:0]        addr_i,
    input  logic                 write_en_i,
    input  logic [AW-1:0]        n_i,
    input  logic [AW-1:0]        k_i,
    input  logic                 swap_i,
    input  logic                 start_i,
`ifdef OPERAND_TRANSPOSE_EN
    input  logic                 transpose_i,
`endif
    output logic [BUS_WIDTH-1:0] read_data_o,
    output logic [BUS_WIDTH-1:0] buff_o,
    output logic                 buff_valid_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 active_bank_o
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;
    // The extra count past the last step is the drain cycle that raises done.
    localparam logic [CW:0] c_end   = (CW+1)'(3*MAX_DIM-2);

    // Bits 0..v set: elements/rows with index <= v are inside the matrix.
    function automatic logic [MAX_DIM-1:0] f_upto_mask(input logic [AW-1:0] v);
        return MAX_DIM'(((MAX_DIM+1)'(2) << v) - (MAX_DIM+1)'(1));
    endfunction

    logic [DATA_WIDTH-1:0] r_bank [2][MAX_DIM][MAX_DIM];
    logic [1:0][AW-1:0]    r_dim_n;
    logic [1:0][AW-1:0]    r_dim_k;
    logic [0:0]            r_state;
    logic [CW:0]           r_cnt;
    logic                  r_active;
    logic                  r_active_valid;
    logic                  r_pending;
    logic [BUS_WIDTH-1:0]  r_buff;
    logic                  r_valid;
    logic                  r_done;

    logic                  w_load;
    logic                  w_addr_ok;
    logic                  w_row_ok;
    logic [MAX_DIM-1:0]    w_kmask_wr;
    logic [AW-1:0]         w_n_act;
    logic [AW-1:0]         w_k_act;
    logic [MAX_DIM-1:0]    w_nmask_act;
    logic [MAX_DIM-1:0]    w_kmask_act;
    logic [BUS_WIDTH-1:0]  w_step;
    logic                  w_transpose;

    assign w_load      = ~r_active;
    assign w_addr_ok   = ({1'b0, addr_i} < (AW+1)'(MAX_DIM));
    assign w_row_ok    = (addr_i <= n_i);
    assign w_kmask_wr  = f_upto_mask(k_i);
    assign w_n_act     = r_dim_n[r_active];
    assign w_k_act     = r_dim_k[r_active];
    assign w_nmask_act = f_upto_mask(w_n_act);
    assign w_kmask_act = f_upto_mask(w_k_act);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < MAX_DIM; r++)
                    for (int c = 0; c < MAX_DIM; c++)
                        r_bank[b][r][c] <= '0;
            r_dim_n <= '0;
            r_dim_k <= '0;
        end else if (write_en_i) begin
            r_dim_n[w_load] <= n_i;
            r_dim_k[w_load] <= k_i;
            if (w_addr_ok) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    if (pstrb_i[c])
                        r_bank[w_load][addr_i][c] <= (w_row_ok && w_kmask_wr[c]) ?
                            pwdata_i[c*DATA_WIDTH +: DATA_WIDTH] : '0;
                end
            end
        end
    end

    always_comb begin
        read_data_o = '0;
        if (w_addr_ok) begin
            for (int c = 0; c < MAX_DIM; c++)
                read_data_o[c*DATA_WIDTH +: DATA_WIDTH] = r_bank[w_load][addr_i][c];
        end
    end

    // Lane r sees diagonal t-r; a negative difference means the row has not started.
    generate
        for (genvar gr = 0; gr < MAX_DIM; gr++) begin : g_lane
            localparam logic [CW:0] c_lane = (CW+1)'(gr);
            logic signed [CW:0]    w_diff;
            logic [CW-1:0]         w_mag;
            logic [AW-1:0]         w_idx;
            logic                  w_norm_ok;
            logic                  w_tr_ok;
            logic                  w_sel_ok;
            logic [DATA_WIDTH-1:0] w_elem;

            assign w_diff    = $signed({1'b0, r_cnt[CW-1:0]}) - $signed(c_lane);
            assign w_mag     = w_diff[CW-1:0];
            assign w_idx     = w_diff[AW-1:0];
            assign w_norm_ok = !w_diff[CW] && (w_mag <= CW'(w_k_act)) && w_nmask_act[gr];
            assign w_tr_ok   = !w_diff[CW] && (w_mag <= CW'(w_n_act)) && w_kmask_act[gr];
            assign w_sel_ok  = w_transpose ? w_tr_ok : w_norm_ok;
            assign w_elem    = w_transpose ? r_bank[r_active][w_idx][gr]
                                           : r_bank[r_active][gr][w_idx];
            assign w_step[gr*DATA_WIDTH +: DATA_WIDTH] = w_sel_ok ? w_elem : '0;
        end
    endgenerate

`ifdef OPERAND_TRANSPOSE_EN
    logic r_transpose;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_transpose <= 1'b0;
        else if (r_state == S_IDLE && start_i && (r_active_valid || swap_i))
            r_transpose <= transpose_i;
    end

    assign w_transpose = r_transpose;
`else
    assign w_transpose = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_active       <= 1'b0;
            r_active_valid <= 1'b0;
            r_pending      <= 1'b0;
            r_buff         <= '0;
            r_valid        <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_buff  <= '0;
                    r_valid <= 1'b0;
                    if (swap_i) begin
                        r_active       <= ~r_active;
                        r_active_valid <= 1'b1;
                    end
                    // A same-cycle swap commits first, so start sees a valid bank.
                    if (start_i && (r_active_valid || swap_i)) begin
                        r_state <= S_STREAM;
                        r_cnt   <= '0;
                    end
                end
                S_STREAM: begin
                    if (swap_i)
                        r_pending <= 1'b1;
                    if (r_cnt == c_end) begin
                        r_state <= S_IDLE;
                        r_buff  <= '0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_pending || swap_i) begin
                            r_active  <= ~r_active;
                            r_pending <= 1'b0;
                        end
                    end else begin
                        r_buff  <= w_step;
                        r_valid <= 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign buff_o        = r_buff;
    assign buff_valid_o  = r_valid;
    assign busy_o        = (r_state == S_STREAM);
    assign done_o        = r_done;
    assign active_bank_o = r_active;

endmodule
`default_nettype wire
